regfile_sb: RTL and testbench

Parametrised register file for the MIPS multicycle datapath. It has two registered read ports and one write port. A same-cycle write-to-read bypass can be enabled by parameter. A per-register busy scoreboard tracks destinations with an outstanding write. After reset, a hardware clear sequencer zeroes the array one entry per cycle, so the storage maps onto single-write-port RAM. It replaces the fixed 32×32 register file between the decode and write-back stages.

---
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a per-entry busy scoreboard and a
// post-reset clear sequencer that zeroes the array through the single write port.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              regwr,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busw,
  input  logic              mark,
  input  logic [ADDR_W-1:0] rm,
  output logic              ready
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  rf [DEPTH];
  logic [DEPTH-1:0]   busy, busy_nxt, busy_src;
  logic               run, wr_en, mk_en, we;
  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  wdata;

  assign run   = (state == RUN);
  assign ready = run;
  assign wr_en = run && regwr && (rw != '0);
  assign mk_en = run && mark && (rm != '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (&idx) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)               idx <= '0;
    else if (state == CLEAR) idx <= idx + 1'b1;
  end

  // Clear sequencer and normal writes share the one array write port.
  always_comb begin
    we    = wr_en;
    waddr = rw;
    wdata = busw;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = idx;
      wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && we) rf[waddr] <= wdata;
  end

  // Mark is applied after the write clear so a simultaneous mark wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[rw] = 1'b0;
    if (mk_en) busy_nxt[rm] = 1'b1;
  end

  assign busy_src = BYPASS ? busy_nxt : busy;

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (a == '0)                    return '0;
    if (BYPASS && wr_en && rw == a) return busw;
    return rf[a];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy   <= '0;
      busa   <= '0;
      busb   <= '0;
      busy_a <= 1'b0;
      busy_b <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (run) begin
        busa   <= rd(ra);
        busb   <= rd(rb);
        busy_a <= busy_src[ra];
        busy_b <= busy_src[rb];
      end else begin
        busa   <= '0;
        busb   <= '0;
        busy_a <= 1'b0;
        busy_b <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one instance with bypass, one without, sharing all inputs.
module tb_regfile_sb;
  logic        clk = 0;
  logic        rst;
  logic [4:0]  ra, rb, rw, rm;
  logic        regwr, mark;
  logic [31:0] busw;
  logic [31:0] busa1, busb1, busa0, busb0;
  logic        bya1, byb1, bya0, byb0, rdy1, rdy0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busa(busa1), .busb(busb1),
    .busy_a(bya1), .busy_b(byb1), .regwr(regwr), .rw(rw), .busw(busw),
    .mark(mark), .rm(rm), .ready(rdy1));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busa(busa0), .busb(busb0),
    .busy_a(bya0), .busy_b(byb0), .regwr(regwr), .rw(rw), .busw(busw),
    .mark(mark), .rm(rm), .ready(rdy0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regwr = 0; mark = 0; rw = 0; rm = 0; busw = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); ra = 5'd3; rb = 5'd17;
    repeat (3) step();
    tests++;
    if ({rdy1, rdy0, bya1, byb1, bya0, byb0} !== 6'b0 || busa1 !== 0 || busb1 !== 0 || busa0 !== 0 || busb0 !== 0) begin
      fails++; $display("FAIL reset_state: rdy=%b%b busy=%b%b%b%b busa=%h busb=%h exp all 0",
                        rdy1, rdy0, bya1, byb1, bya0, byb0, busa1, busb1);
    end
    rst = 1;
    for (int i = 0; i < 32; i++) begin
      step();
      tests++;
      if (rdy1 !== (i == 31) || rdy0 !== (i == 31)) begin
        fails++; $display("FAIL clear_ready edge %0d: got %b/%b exp %b", i + 1, rdy1, rdy0, i == 31);
      end
      tests++;
      if (busa1 !== 0 || busb1 !== 0) begin
        fails++; $display("FAIL clear_bus edge %0d: busa=%h busb=%h exp 0", i + 1, busa1, busb1);
      end
    end
    ra = 5'd1; rb = 5'd31;
    step();
    tests++;
    if (busa1 !== 0 || busb1 !== 0 || busa0 !== 0 || busb0 !== 0) begin
      fails++; $display("FAIL cleared_read: busa=%h busb=%h exp 0", busa1, busb1);
    end
  endtask

  task automatic test_basic();
    regwr = 1; rw = 5'd5; busw = 32'hDEADBEEF; ra = 0; rb = 0;
    step();
    regwr = 0; ra = 5'd5; rb = 0;
    step();
    tests++;
    if (busa1 !== 32'hDEADBEEF || busa0 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL basic_read: got %h/%h exp deadbeef", busa1, busa0);
    end
    tests++;
    if (busb1 !== 0 || busb0 !== 0) begin
      fails++; $display("FAIL basic_r0: got %h/%h exp 0", busb1, busb0);
    end
    regwr = 1; rw = 0; busw = 32'h1234; ra = 0; rb = 5'd5;
    step();
    regwr = 0;
    step();
    tests++;
    if (busa1 !== 0 || busa0 !== 0 || busb1 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL write_r0: busa=%h/%h busb=%h exp 0/0/deadbeef", busa1, busa0, busb1);
    end
  endtask

  task automatic test_bypass();
    regwr = 1; rw = 5'd7; busw = 32'hA5A5A5A5; ra = 5'd7; rb = 5'd5;
    step();
    tests++;
    if (busa1 !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL bypass_on: got %h exp a5a5a5a5", busa1);
    end
    tests++;
    if (busa0 !== 0) begin
      fails++; $display("FAIL bypass_off: got %h exp 0", busa0);
    end
    regwr = 0;
    step();
    tests++;
    if (busa0 !== 32'hA5A5A5A5 || busb0 !== 32'hDEADBEEF) begin
      fails++; $display("FAIL bypass_next: busa=%h busb=%h exp a5a5a5a5/deadbeef", busa0, busb0);
    end
  endtask

  task automatic test_scoreboard();
    mark = 1; rm = 5'd9; ra = 5'd9; rb = 5'd7;
    step();
    tests++;
    if (bya1 !== 1 || bya0 !== 0 || byb1 !== 0) begin
      fails++; $display("FAIL mark_same: busy_a=%b/%b busy_b=%b exp 1/0/0", bya1, bya0, byb1);
    end
    mark = 0;
    step();
    tests++;
    if (bya1 !== 1 || bya0 !== 1) begin
      fails++; $display("FAIL pending: busy_a=%b/%b exp 1/1", bya1, bya0);
    end
    regwr = 1; rw = 5'd9; busw = 32'h99;
    step();
    tests++;
    if (bya1 !== 0 || bya0 !== 1 || busa1 !== 32'h99) begin
      fails++; $display("FAIL write_clear: busy_a=%b/%b busa=%h exp 0/1/99", bya1, bya0, busa1);
    end
    regwr = 0;
    step();
    tests++;
    if (bya1 !== 0 || bya0 !== 0 || busa0 !== 32'h99) begin
      fails++; $display("FAIL cleared: busy_a=%b/%b busa=%h exp 0/0/99", bya1, bya0, busa0);
    end
    mark = 1; rm = 5'd9; regwr = 1; rw = 5'd9; busw = 32'h77; rb = 5'd9;
    step();
    tests++;
    if (byb1 !== 1 || byb0 !== 0) begin
      fails++; $display("FAIL mark_wins_same: busy_b=%b/%b exp 1/0", byb1, byb0);
    end
    mark = 0; regwr = 0;
    step();
    tests++;
    if (bya1 !== 1 || bya0 !== 1 || busa0 !== 32'h77 || busa1 !== 32'h77) begin
      fails++; $display("FAIL mark_wins: busy_a=%b/%b busa=%h/%h exp 1/1/77/77", bya1, bya0, busa1, busa0);
    end
  endtask

  task automatic test_reset_mid();
    regwr = 1; rw = 5'd3; busw = 32'h55; ra = 5'd9; rb = 5'd3;
    step();
    regwr = 0; ra = 5'd3;
    step();
    tests++;
    if (busa1 !== 32'h55 || busa0 !== 32'h55) begin
      fails++; $display("FAIL pre_reset: got %h/%h exp 55", busa1, busa0);
    end
    rst = 0; ra = 5'd9;
    step();
    tests++;
    if (rdy1 !== 0 || busa1 !== 0 || bya1 !== 0 || bya0 !== 0) begin
      fails++; $display("FAIL mid_reset: rdy=%b busa=%h busy_a=%b/%b exp 0", rdy1, busa1, bya1, bya0);
    end
    // Traffic during CLEAR must be discarded.
    rst = 1; regwr = 1; rw = 5'd4; busw = 32'hFF; mark = 1; rm = 5'd4;
    for (int i = 0; i < 32; i++) begin
      step();
      tests++;
      if (rdy1 !== (i == 31) || rdy0 !== (i == 31)) begin
        fails++; $display("FAIL reclear_ready edge %0d: got %b/%b exp %b", i + 1, rdy1, rdy0, i == 31);
      end
    end
    idle(); ra = 5'd3; rb = 5'd4;
    step();
    tests++;
    if (busa1 !== 0 || busa0 !== 0) begin
      fails++; $display("FAIL r3_cleared: got %h/%h exp 0", busa1, busa0);
    end
    tests++;
    if (busb1 !== 0 || busb0 !== 0 || byb1 !== 0 || byb0 !== 0) begin
      fails++; $display("FAIL ignored_r4: busb=%h/%h busy_b=%b/%b exp 0", busb1, busb0, byb1, byb0);
    end
    ra = 5'd9;
    step();
    tests++;
    if (bya1 !== 0 || bya0 !== 0) begin
      fails++; $display("FAIL busy_reset: busy_a=%b/%b exp 0", bya1, bya0);
    end
  endtask

  initial begin
    rst = 0; ra = 0; rb = 0; idle();
    test_reset();
    test_basic();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
